// File: rtl/dn_router.sv
// dn_router: routes the HPS ioctl download stream onto BIOS / sprite / music write strobes, with limits, stats and CPU hold.
// One-cycle write latency, no backpressure (every ioctl_wr is taken or dropped); DN_ROUTER_CHECKSUM_EN adds a data checksum.
module dn_router #(
  parameter int unsigned       ADDR_W       = 17,
  parameter logic [ADDR_W-1:0] BIOS_LIMIT   = 17'h10000,
  parameter logic [ADDR_W-1:0] SPRITE_LIMIT = 17'h08000,
  parameter logic [ADDR_W-1:0] MUSIC_LIMIT  = 17'h1FFFF,
  parameter int unsigned       HOLD_CYCLES  = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr_bios,
  output logic              dn_wr_sprite,
  output logic              dn_wr_music,
  output logic [7:0]        dn_index,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [17:0]       byte_count,
  output logic [7:0]        checksum
);

  localparam int unsigned CNT_W   = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_LOAD  = 2'd1;
  localparam logic [1:0]  S_FLUSH = 2'd2;
  localparam logic [17:0] CNT_MAX = 18'h3FFFF;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              download_q, seen_low_q;
  logic [7:0]        index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_bios_q, wr_sprite_q, wr_music_q;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [17:0]       count_q, count_d;
  logic              start, stop, active;
  logic [7:0]        cur_index;
  logic              sel_bios, sel_sprite, sel_music;
  logic              wr_req, in_range, accept;
  logic [24:0]       limit;

  // seen_low_q keeps a download left high across reset from posing as a new session.
  always_comb begin
    start      = ioctl_download & ~download_q & seen_low_q;
    stop       = ~ioctl_download & download_q;
    active     = start | (state_q == S_LOAD);
    cur_index  = start ? ioctl_index : index_q;
    sel_bios   = (cur_index == 8'd0) | (cur_index == 8'd1);
    sel_sprite = (cur_index == 8'd3);
    sel_music  = (cur_index == 8'd4);
    limit      = '0;
    if (sel_bios)        limit = 25'(BIOS_LIMIT);
    else if (sel_sprite) limit = 25'(SPRITE_LIMIT);
    else if (sel_music)  limit = 25'(MUSIC_LIMIT);
    wr_req   = ioctl_wr & ioctl_download & active & (sel_bios | sel_sprite | sel_music);
    in_range = (ioctl_addr < limit);
    accept   = wr_req & in_range;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    index_d = index_q;
    if (start) begin
      state_d = S_LOAD;
      index_d = ioctl_index;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (stop) begin
            state_d = S_FLUSH;
            hold_d  = CNT_W'(HOLD_CYCLES - 1);
          end
        end
        S_FLUSH: begin
          if (hold_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf_d   = (start ? 1'b0 : ovf_q) | (wr_req & ~in_range);
    count_d = start ? '0 : count_q;
    if (accept && (count_d != CNT_MAX)) count_d = count_d + 18'd1;
    addr_d  = accept ? ioctl_addr[ADDR_W-1:0] : addr_q;
    data_d  = accept ? ioctl_dout : data_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      download_q  <= 1'b0;
      seen_low_q  <= 1'b0;
      index_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_bios_q   <= 1'b0;
      wr_sprite_q <= 1'b0;
      wr_music_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      download_q  <= ioctl_download;
      seen_low_q  <= seen_low_q | ~ioctl_download;
      index_q     <= index_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_bios_q   <= accept & sel_bios;
      wr_sprite_q <= accept & sel_sprite;
      wr_music_q  <= accept & sel_music;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

`ifdef DN_ROUTER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = start ? 8'h00 : sum_q;
    if (accept) sum_d = sum_d + ioctl_dout;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

  assign busy         = (state_q != S_IDLE);
  assign cpu_hold     = busy & (index_q < 8'd2);
  assign dn_addr      = addr_q;
  assign dn_data      = data_q;
  assign dn_wr_bios   = wr_bios_q;
  assign dn_wr_sprite = wr_sprite_q;
  assign dn_wr_music  = wr_music_q;
  assign dn_index     = index_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign byte_count   = count_q;

endmodule

// File: tb/tb_dn_router.sv
// Bench for dn_router: directed download sessions plus randomized sessions checked against a session-level model.
module tb_dn_router;

  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr_bios, dn_wr_sprite, dn_wr_music;
  logic [7:0]  dn_index;
  logic        cpu_hold, busy, done, overflow;
  logic [17:0] byte_count;
  logic [7:0]  checksum;

  dn_router dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wr_bios(dn_wr_bios), .dn_wr_sprite(dn_wr_sprite), .dn_wr_music(dn_wr_music),
    .dn_index(dn_index), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .overflow(overflow), .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int miscompares = 0;

  // Session-level reference model.
  logic [7:0]  m_index = '0;
  int          m_count = 0;
  int          m_sum = 0;
  logic        m_ovf = 1'b0;
  logic        m_load = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [16:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  int          exp_t = 0;

  function automatic int tgt_of(input logic [7:0] idx);
    case (idx)
      8'd0, 8'd1: return 1;
      8'd3:       return 2;
      8'd4:       return 3;
      default:    return 0;
    endcase
  endfunction

  function automatic int unsigned lim_of(input int t);
    case (t)
      1:       return 32'h10000;
      2:       return 32'h08000;
      3:       return 32'h1FFFF;
      default: return 32'h10000;
    endcase
  endfunction

  function automatic logic [24:0] gen_addr(input logic [7:0] idx);
    int unsigned lim;
    lim = lim_of(tgt_of(idx));
    case ($urandom_range(0, 4))
      0:       return 25'(lim - 1);
      1:       return 25'(lim);
      2:       return 25'($urandom_range(0, lim - 1));
      3:       return 25'($urandom);
      default: return 25'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_sum;
`ifdef DN_ROUTER_CHECKSUM_EN
    exp_sum = 8'(m_sum);
`else
    exp_sum = 8'h00;
`endif
    chk("dn_wr_bios", 32'(dn_wr_bios), 32'(exp_t == 1));
    chk("dn_wr_sprite", 32'(dn_wr_sprite), 32'(exp_t == 2));
    chk("dn_wr_music", 32'(dn_wr_music), 32'(exp_t == 3));
    chk("dn_addr", 32'(dn_addr), 32'(m_addr));
    chk("dn_data", 32'(dn_data), 32'(m_data));
    chk("byte_count", 32'(byte_count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("checksum", 32'(checksum), 32'(exp_sum));
    chk("dn_index", 32'(dn_index), 32'(m_index));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_busy && (m_index < 8'd2)));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    check_all();
    exp_t    = 0;
    ioctl_wr = 1'b0;
  endtask

  task automatic drive_wr(input logic [24:0] a, input logic [7:0] d);
    int t;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    exp_t      = 0;
    t          = tgt_of(m_index);
    if (m_load && t != 0) begin
      if (a < lim_of(t)) begin
        exp_t  = t;
        m_addr = a[16:0];
        m_data = d;
        m_sum  = (m_sum + int'(d)) % 256;
        if (m_count < 32'h3FFFF) m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic start_session(input logic [7:0] idx, input bit with_wr,
                               input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    m_index = idx; m_count = 0; m_sum = 0; m_ovf = 1'b0;
    m_load  = 1'b1; m_busy = 1'b1; m_done = 1'b0;
    if (with_wr) drive_wr(a, d);
    step();
    ioctl_index = 8'($urandom);
  endtask

  // restart_at != 0 leaves the block in FLUSH just before that flush cycle.
  task automatic end_session(input int restart_at);
    ioctl_download = 1'b0;
    m_load = 1'b0;
    step();
    if (restart_at != 0) begin
      for (int k = 1; k < restart_at; k++) step();
    end else begin
      for (int k = 1; k <= HOLD; k++) begin
        if (k == HOLD) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
        step();
      end
      m_done = 1'b0;
      step();
    end
  endtask

  task automatic model_reset();
    m_index = '0; m_count = 0; m_sum = 0; m_ovf = 1'b0;
    m_load = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_addr = '0; m_data = '0; exp_t = 0;
  endtask

  initial begin
    logic [7:0] bdat [4];
    logic [7:0] idx;
    int nw, rs;
    bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_all();
    step();
    step();
    reset_n = 1'b1;
    step();
    step();

    // Normal BIOS load
    start_session(8'd0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_wr(25'(i), bdat[i]);
      step();
    end
    end_session(0);

    // Sprite overflow
    start_session(8'd3, 1'b0, '0, '0);
    drive_wr(25'h07FFF, 8'h5A); step();
    drive_wr(25'h08000, 8'hA5); step();
    step();
    end_session(0);

    // Unknown index
    start_session(8'd2, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      drive_wr(25'(i), 8'(i + 1)); step();
    end
    end_session(0);

    // Restart during FLUSH
    start_session(8'd4, 1'b0, '0, '0);
    drive_wr(25'h00100, 8'h77); step();
    drive_wr(25'h1FFFE, 8'h01); step();
    end_session(5);
    start_session(8'd0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) step();
    drive_wr(25'h0FFFF, 8'hC3); step();
    end_session(0);

    // Reset mid-load with the download left high
    start_session(8'd0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      drive_wr(25'(i), 8'(8'hE0 + i)); step();
    end
    ioctl_wr = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    ioctl_wr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    drive_wr(25'h00010, 8'h99); step();
    step();
    ioctl_download = 1'b0;
    step();
    step();
    start_session(8'd0, 1'b0, '0, '0);
    drive_wr(25'h00020, 8'h42); step();
    end_session(0);

    // Write in the start cycle
    start_session(8'd4, 1'b1, 25'h0, 8'h3C);
    step();
    end_session(0);

    // Randomized sessions
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 7))
        0:       idx = 8'd0;
        1:       idx = 8'd1;
        2:       idx = 8'd2;
        3:       idx = 8'd3;
        4:       idx = 8'd4;
        5:       idx = 8'd5;
        6:       idx = 8'hFF;
        default: idx = 8'($urandom);
      endcase
      start_session(idx, $urandom_range(0, 3) == 0, gen_addr(idx), 8'($urandom));
      nw = $urandom_range(0, 12);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) step();
        drive_wr(gen_addr(idx), 8'($urandom));
        step();
      end
      rs = (s != 23 && $urandom_range(0, 3) == 0) ? $urandom_range(1, HOLD - 1) : 0;
      end_session(rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dn_router.md
Name: dn_router

Overview:
- Sits between the HPS ioctl download stream and the core's memories; it is the stage that generates the core's `dn_*` write stream.
- Latches the download index at session start and routes each byte, one cycle later, to the BIOS, sprite ROM or music RAM write strobe.
- Enforces per-target size limits and counts accepted bytes.
- Generates a CPU hold that covers BIOS loads plus a fixed post-load settle period.

Parameters:
- ADDR_W, 17: width of the routed address.
- BIOS_LIMIT, 17'h10000: max bytes accepted for index 0/1.
- SPRITE_LIMIT, 17'h08000: max bytes accepted for index 3.
- MUSIC_LIMIT, 17'h1FFFF: max bytes accepted for index 4.
- HOLD_CYCLES, 16: FLUSH length in clocks after download ends; must be ≥1.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ioctl_download, in, 1: download session active.
- ioctl_wr, in, 1: byte strobe, one cycle per byte.
- ioctl_addr, in, 25: byte address within the file.
- ioctl_dout, in, 8: byte data.
- ioctl_index, in, 8: file index.
- dn_addr, out, ADDR_W: registered address, equal to ioctl_addr[ADDR_W-1:0].
- dn_data, out, 8: registered data.
- dn_wr_bios, out, 1: write strobe, BIOS.
- dn_wr_sprite, out, 1: write strobe, sprite ROM.
- dn_wr_music, out, 1: write strobe, music RAM.
- dn_index, out, 8: index latched for the current or last session.
- cpu_hold, out, 1: hold the CPU in reset.
- busy, out, 1: high in LOAD or FLUSH.
- done, out, 1: one-cycle pulse at the end of FLUSH.
- overflow, out, 1: sticky; a write hit the target limit.
- byte_count, out, 18: accepted bytes this session, saturates at 18'h3FFFF.
- checksum, out, 8: see Optional Feature.

Behaviour:
- Interface:
  - Single clock, clk_sys.
  - reset_n is asynchronous and active-low.
  - While reset_n = 0, and on its release, every output is 0 and the FSM is in IDLE.
- Session start edge detection:
  - download_q is ioctl_download registered.
  - Start = ioctl_download & ~download_q.
  - End = ~ioctl_download & download_q.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - On start: latch ioctl_index into dn_index; clear byte_count, overflow and checksum; go to LOAD.
  - A write arriving in the same cycle as start is accepted and routed using the new index.
- LOAD:
  - On end: go to FLUSH and load the hold counter with HOLD_CYCLES-1.
  - Changes on ioctl_index during LOAD are ignored.
- FLUSH:
  - The counter decrements each clock.
  - At 0: pulse done for 1 cycle and go to IDLE.
  - If start arrives during FLUSH: re-latch the index, clear stats, go to LOAD. No done pulse is issued.
- Write acceptance:
  - A write is accepted when ioctl_wr = 1, ioctl_download = 1, the state is LOAD (or the start cycle), the latched index maps to a target, and ioctl_addr < that target's limit.
  - The comparison uses the full 25-bit address.
- Write latency:
  - A write accepted in cycle N produces exactly one of dn_wr_* high in cycle N+1.
  - dn_addr and dn_data are valid in that same cycle N+1.
  - dn_addr and dn_data hold their value between writes.
- Index map:
  - Index 0 and 1: BIOS.
  - Index 3: sprite ROM.
  - Index 4: music RAM.
  - Any other index: the write is dropped with no strobe. overflow is not set and byte_count does not change.
- Limit check:
  - If ioctl_addr ≥ the target's limit, the write is suppressed and overflow is set to 1.
  - overflow stays set until the next start or reset.
- byte_count:
  - Increments by 1 for each accepted write.
  - Saturates at 18'h3FFFF.
- cpu_hold:
  - High during LOAD and FLUSH when dn_index < 2.
  - Asserts in the start cycle +1.
  - Drops in the same cycle done pulses.
- busy is high exactly when the state is LOAD or FLUSH.
- Asynchronous reset mid-session:
  - Returns the block immediately to IDLE with all outputs 0.
  - If the download is still high after reset_n rises, it is not treated as a session until ioctl_download falls and rises again. This holds because download_q resets to 1-masked: a "seen_low" flag resets to 0 and gates start.

Optional Feature:
- Macro: DN_ROUTER_CHECKSUM_EN.
- With the macro defined:
  - checksum is an 8-bit modulo-256 sum of the data of every accepted write.
  - It updates in the same cycle as the corresponding dn_wr_* strobe.
  - It is cleared on start.
  - It holds its value after done until the next start.
- Without the macro: checksum is tied to 8'h00 and no adder is synthesised.

Test Plan:
- Normal BIOS load:
  - Stimulus: reset, then ioctl_download rise with index 0; write 4 bytes (addr 0..3, data 8'h11, 8'h22, 8'h33, 8'h44); ioctl_download fall.
  - Required: dn_wr_bios pulses one cycle after each write with matching addr and data; byte_count = 4; cpu_hold high throughout; done pulses 16 clocks after the fall; checksum = 8'hAA when the macro is defined.
- Sprite overflow:
  - Stimulus: index 3, writes at addr 17'h07FFF and 17'h08000.
  - Required: first write strobes dn_wr_sprite; second write gives no strobe and sets overflow = 1; byte_count = 1; cpu_hold stays 0.
- Unknown index:
  - Stimulus: index 2 with 10 writes.
  - Required: no dn_wr_* strobe; byte_count = 0; overflow = 0; busy high; done pulses after FLUSH.
- Restart during FLUSH:
  - Stimulus: end a music download (index 4), then re-raise download with index 0 at FLUSH cycle 5.
  - Required: no done pulse; dn_index = 0; stats cleared; cpu_hold rises.
- Reset mid-load:
  - Stimulus: pull reset_n low after 3 BIOS writes while download stays high; release reset_n; later drop and re-raise download.
  - Required: all outputs 0 while reset_n is low; no session while the stale download remains high; a new session starts only on the fresh rise.
- Write in the start cycle:
  - Stimulus: ioctl_wr asserted in the same cycle ioctl_download rises, index 4, addr 0.
  - Required: dn_wr_music pulses in the next cycle; byte_count = 1.
